// File: rtl/fwd_hazard_unit_pkg.sv
// Shared forwarding-select encoding and hazard tag types for the ID/EX forwarding logic.
package fwd_hazard_unit_pkg;

  localparam int unsigned REG_BITS = 5;

  typedef enum logic [1:0] {
    FW_REG   = 2'd0,
    FW_EXMEM = 2'd1,
    FW_MEMWB = 2'd2,
    FW_RET   = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } hz_slot_t;

  // Slots past EX only ever need "does it still produce rd", so they keep a reduced tag.
  typedef struct packed {
    logic                live;
    logic [REG_BITS-1:0] rd;
  } hz_tag_t;

  function automatic logic slot_live(input hz_slot_t s);
    return s.valid & s.reg_write & (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source index against the EX/MEM/WB producer tags; the youngest matching producer wins.
module fwd_src_match
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_BITS-1:0] rs,
  input  logic                use_rs,
  input  logic                ex_live,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                mem_live,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic                wb_live,
  input  logic [REG_BITS-1:0] wb_rd,
  output fwd_sel_t            sel
);

  always_comb begin
    sel = FW_REG;
    if (use_rs && (rs != '0)) begin
      if (ex_live && (rs == ex_rd))
        sel = FW_EXMEM;
      else if (mem_live && (rs == mem_rd))
        sel = FW_MEMWB;
      else if (wb_live && (rs == wb_rd))
        sel = FW_RET;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow tag pipeline feeding registered EX forwarding selects plus the load-use stall.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic [SEL_W-1:0]    SelFwA,
  output logic [SEL_W-1:0]    SelFwB,
  output logic                stall,
  output logic                bubble,
  output logic [CNT_W-1:0]    stall_count
);

  hz_slot_t ex_slot;
  hz_tag_t  mem_tag;
  hz_tag_t  wb_tag;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     ex_live;
  logic     ex_alu_live;
  logic     load_hit;

  assign ex_live     = slot_live(ex_slot);
  // A load still in EX has no data for Fw1; the stall turns it into a MEM-slot match instead.
  assign ex_alu_live = ex_live & ~ex_slot.mem_read;
  assign load_hit    = ex_live & ex_slot.mem_read &
                       ((id_use_rs1 & (id_rs1 == ex_slot.rd)) |
                        (id_use_rs2 & (id_rs2 == ex_slot.rd)));

  assign stall  = ~rst & id_valid & ~flush & load_hit;
  assign bubble = rst | stall | flush | ~id_valid;

  fwd_src_match u_match_a (
    .rs       (id_rs1),
    .use_rs   (id_use_rs1),
    .ex_live  (ex_alu_live),
    .ex_rd    (ex_slot.rd),
    .mem_live (mem_tag.live),
    .mem_rd   (mem_tag.rd),
    .wb_live  (wb_tag.live),
    .wb_rd    (wb_tag.rd),
    .sel      (sel_a)
  );

  fwd_src_match u_match_b (
    .rs       (id_rs2),
    .use_rs   (id_use_rs2),
    .ex_live  (ex_alu_live),
    .ex_rd    (ex_slot.rd),
    .mem_live (mem_tag.live),
    .mem_rd   (mem_tag.rd),
    .wb_live  (wb_tag.live),
    .wb_rd    (wb_tag.rd),
    .sel      (sel_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot     <= '0;
      mem_tag     <= '0;
      wb_tag      <= '0;
      SelFwA      <= '0;
      SelFwB      <= '0;
      stall_count <= '0;
    end else begin
      mem_tag <= '{live: ex_live, rd: ex_slot.rd};
      wb_tag  <= mem_tag;
      if (bubble) begin
        ex_slot <= '0;
        SelFwA  <= '0;
        SelFwB  <= '0;
      end else begin
        ex_slot <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        SelFwA  <= SEL_W'(sel_a);
        SelFwB  <= SEL_W'(sel_b);
      end
      if (stall)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scenario bench for fwd_hazard_unit: expected selects queued at issue, popped after the ID->EX edge.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [1:0]  SelFwA;
  logic [1:0]  SelFwB;
  logic        stall;
  logic        bubble;
  logic [31:0] stall_count;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.SEL_W(2), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .SelFwA       (SelFwA),
    .SelFwB       (SelFwB),
    .stall        (stall),
    .bubble       (bubble),
    .stall_count  (stall_count)
  );

  // Drive one ID-stage instruction at the falling edge and queue the selects it must get in EX.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    sb.push_back('{a: ea, b: eb});
    #1;
  endtask

  task automatic tick_pop(output exp_t e, output bit ok);
    @(posedge clk);
    #1;
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : '0;
  endtask

  task automatic drain();
    exp_t e;
    bit   ok;
    for (int unsigned i = 0; i < 3; i++) begin
      issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      tick_pop(e, ok);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    rst = 1'b1;
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || bubble !== 1'b1) begin
      errors++; $display("FAIL reset_comb: stall=%0b bubble=%0b want 0/1", stall, bubble);
    end
    tick_pop(e, ok);
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL reset_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", stall_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    drain();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1);
    checks++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      errors++; $display("FAIL b2b_stall: stall=%0b bubble=%0b want 0/0", stall, bubble);
    end
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL b2b_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
  endtask

  // Producer x5, then n nops, then sub x7,x5,x1: select must track distance.
  task automatic test_distance();
    exp_t       e;
    bit         ok;
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    for (int unsigned n = 0; n < 4; n++) begin
      drain();
      issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      tick_pop(e, ok);
      for (int unsigned k = 0; k < n; k++) begin
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        tick_pop(e, ok);
      end
      issue(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, want[n], 2'd0);
      tick_pop(e, ok);
      checks++;
      if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
        errors++; $display("FAIL distance_%0d: got %0d/%0d want %0d/%0d", n, SelFwA, SelFwB, e.a, e.b);
      end
    end
    // Two writers of x5 in flight: the younger (EX) must win over MEM.
    drain();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL youngest_wins: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    bit   ok;
    int   cnt0;
    drain();
    cnt0 = int'(stall_count);
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: stall=%0b bubble=%0b want 1/1", stall, bubble);
    end
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL load_use_bubble_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
    checks++;
    if (stall_count !== 32'(cnt0 + 1)) begin
      errors++; $display("FAIL load_use_count: got %0d want %0d", stall_count, cnt0 + 1);
    end
    issue(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL load_use_release: stall=%0b want 0", stall);
    end
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL load_use_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
  endtask

  task automatic test_x0_unused();
    exp_t e;
    bit   ok;
    drain();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL x0_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
    drain();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL unused_rs2: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    bit   ok;
    int   cnt0;
    drain();
    cnt0 = int'(stall_count);
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    issue(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || bubble !== 1'b1) begin
      errors++; $display("FAIL flush_comb: stall=%0b bubble=%0b want 0/1", stall, bubble);
    end
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b || stall_count !== 32'(cnt0)) begin
      errors++; $display("FAIL flush_state: sel %0d/%0d cnt %0d want %0d/%0d cnt %0d",
                         SelFwA, SelFwB, stall_count, e.a, e.b, cnt0);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    drain();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    rst = 1'b1;
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || bubble !== 1'b1) begin
      errors++; $display("FAIL reset_mid_comb: stall=%0b bubble=%0b want 0/1", stall, bubble);
    end
    tick_pop(e, ok);
    rst = 1'b0;
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick_pop(e, ok);
    checks++;
    if (!ok || SelFwA !== e.a || SelFwB !== e.b) begin
      errors++; $display("FAIL reset_mid_sel: got %0d/%0d want %0d/%0d", SelFwA, SelFwB, e.a, e.b);
    end
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_mid_count: got %0d want 0", stall_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
